// File: rtl/branch_resolve_if.sv
// Execute-to-fetch branch resolution bus: op/flag inputs, registered redirect
// result, and statistics counters.
interface branch_resolve_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic             is_branch;
   logic             is_jal;
   logic             is_jalr;
   logic [2:0]       funct3;
   logic [3:0]       flag;
   logic [XLEN-1:0]  alu_rslt;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic             pred_taken;
   logic             out_valid;
   logic             out_ready;
   logic             taken;
   logic             redirect;
   logic [XLEN-1:0]  next_pc;
   logic             misalign;
   logic             illegal;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] mis_cnt;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid-side payload stays stable until that edge.
   modport master (
      output flush, in_valid, is_branch, is_jal, is_jalr, funct3, flag,
             alu_rslt, pc, imm, pred_taken, out_ready,
      input  in_ready, out_valid, taken, redirect, next_pc, misalign, illegal,
             br_cnt, mis_cnt
   );

   modport slave (
      input  flush, in_valid, is_branch, is_jal, is_jalr, funct3, flag,
             alu_rslt, pc, imm, pred_taken, out_ready,
      output in_ready, out_valid, taken, redirect, next_pc, misalign, illegal,
             br_cnt, mis_cnt
   );
endinterface

// File: rtl/branch_resolve.sv
// Resolves branch/jal/jalr outcome from ALU flags, registers the redirect for
// fetch behind a one-entry output buffer, and keeps saturating statistics.
module branch_resolve #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   branch_resolve_if.slave  bus,
   output logic             dbg_full
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

   state_e           state_q, state_d;
   logic             taken_q, taken_d;
   logic             redirect_q, redirect_d;
   logic [XLEN-1:0]  next_pc_q, next_pc_d;
   logic             misalign_q, misalign_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

   logic             op_jalr, op_jal, op_br;
   logic             flag_z, flag_n, flag_c, flag_v;
   logic             cond_c, illegal_c, taken_c, redirect_c, misalign_c;
   logic [XLEN-1:0]  target_c, seq_pc_c, next_pc_c;
   logic             in_ready_c, accept_c;

   // Op decode with jalr > jal > branch priority, then condition from flags.
   always_comb begin
      op_jalr   = bus.is_jalr;
      op_jal    = bus.is_jal & ~bus.is_jalr;
      op_br     = bus.is_branch & ~bus.is_jal & ~bus.is_jalr;
      flag_z    = bus.flag[0];
      flag_n    = bus.flag[1];
      flag_c    = bus.flag[2];
      flag_v    = bus.flag[3];
      cond_c    = 1'b0;
      illegal_c = 1'b0;
      case (bus.funct3)
         3'b000:  cond_c = flag_z;
         3'b001:  cond_c = ~flag_z;
         3'b100:  cond_c = flag_n ^ flag_v;
         3'b101:  cond_c = ~(flag_n ^ flag_v);
         3'b110:  cond_c = ~flag_c;
         3'b111:  cond_c = flag_c;
         default: illegal_c = op_br;
      endcase
      taken_c    = op_jalr | op_jal | (op_br & cond_c);
      target_c   = op_jalr ? {bus.alu_rslt[XLEN-1:1], 1'b0} : bus.pc + bus.imm;
      seq_pc_c   = bus.pc + XLEN'(4);
      next_pc_c  = taken_c ? target_c : seq_pc_c;
      misalign_c = taken_c & (target_c[1:0] != 2'b00);
      redirect_c = taken_c ^ bus.pred_taken;
   end

   always_comb begin
      in_ready_c = ~bus.flush & ((state_q == S_EMPTY) | bus.out_ready);
      accept_c   = bus.in_valid & in_ready_c
                   & (bus.is_branch | bus.is_jal | bus.is_jalr);
   end

   always_comb begin
      state_d    = state_q;
      taken_d    = taken_q;
      redirect_d = redirect_q;
      next_pc_d  = next_pc_q;
      misalign_d = misalign_q;
      illegal_d  = illegal_q;
      br_cnt_d   = br_cnt_q;
      mis_cnt_d  = mis_cnt_q;
      if (bus.flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: if (accept_c) state_d = S_FULL;
            S_FULL:  if (bus.out_ready) state_d = accept_c ? S_FULL : S_EMPTY;
            default: state_d = S_EMPTY;
         endcase
      end
      // accept_c already excludes flush, so a flushed op never loads or counts.
      if (accept_c) begin
         taken_d    = taken_c;
         redirect_d = redirect_c;
         next_pc_d  = next_pc_c;
         misalign_d = misalign_c;
         illegal_d  = illegal_c;
         if (!(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_W'(1);
         if (redirect_c && !(&mis_cnt_q)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         taken_q    <= 1'b0;
         redirect_q <= 1'b0;
         next_pc_q  <= '0;
         misalign_q <= 1'b0;
         illegal_q  <= 1'b0;
         br_cnt_q   <= '0;
         mis_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         taken_q    <= taken_d;
         redirect_q <= redirect_d;
         next_pc_q  <= next_pc_d;
         misalign_q <= misalign_d;
         illegal_q  <= illegal_d;
         br_cnt_q   <= br_cnt_d;
         mis_cnt_q  <= mis_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = (state_q == S_FULL);
   assign bus.taken     = taken_q;
   assign bus.redirect  = redirect_q;
   assign bus.next_pc   = next_pc_q;
   assign bus.misalign  = misalign_q;
   assign bus.illegal   = illegal_q;
   assign bus.br_cnt    = br_cnt_q;
   assign bus.mis_cnt   = mis_cnt_q;
   assign dbg_full      = (state_q == S_FULL);

endmodule
